smoothing_stream: RTL and testbench

Streaming 3x3 smoothing filter for raster-scan pixel streams, generalised in pixel width and frame size.
- Sits between the pixel source and downstream feature blocks.
- Two line buffers plus a 3x3 window register; one output pixel per valid interior window.
- Valid/ready handshaking on both sides, with full backpressure.

---
 rtl/smoothing_pkg.sv | 28 ++
 rtl/smoothing_stream_if.sv | 25 ++
 rtl/smoothing_line_buf.sv | 30 +++
 rtl/smoothing_stream.sv | 127 ++++++++++++
 tb/tb_smoothing_stream.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/smoothing_pkg.sv
// Shared constants and helpers for the 3x3 smoothing stream filter.
// Kernel weights, rounding offsets, accumulator width and the reciprocal-of-9
// multiplier used to turn the box divide into a constant multiply.
package smoothing_pkg;

   localparam int unsigned ROUND_BOX   = 4;
   localparam int unsigned ROUND_GAUSS = 8;
   localparam int unsigned GAUSS_SHIFT = 4;

   localparam int unsigned BOX_K   [3][3] = '{'{1, 1, 1}, '{1, 1, 1}, '{1, 1, 1}};
   localparam int unsigned GAUSS_K [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};

   // Weighted sum of nine pixels never exceeds 16 * max pixel.
   function automatic int unsigned sum_width(input int unsigned pix_w);
      return pix_w + 4;
   endfunction

   // With M = ceil(2^S / 9) the error term is at most 8, so floor(x * M >> S) == floor(x / 9)
   // holds for every x < 2^(pix_w + 4) once S >= pix_w + 7.
   function automatic int unsigned recip9_shift(input int unsigned pix_w);
      return pix_w + 7;
   endfunction

   function automatic longint unsigned recip9_mult(input int unsigned pix_w);
      return ((64'd1 << recip9_shift(pix_w)) + 64'd8) / 64'd9;
   endfunction

endpackage

// File: rtl/smoothing_stream_if.sv
// Pixel stream bundle for smoothing_stream: input handshake, output handshake, frame marker.
// master = pixel source / sink side, slave = the filter.
interface smoothing_stream_if #(
   parameter int unsigned PIX_W = 8
) ();

   logic             in_valid;
   logic             in_ready;
   logic [PIX_W-1:0] pixel_in;
   logic             out_valid;
   logic             out_ready;
   logic [PIX_W-1:0] pixel_out;
   logic             out_last;

   modport master (
      output in_valid, pixel_in, out_ready,
      input  in_ready, out_valid, pixel_out, out_last
   );

   modport slave (
      input  in_valid, pixel_in, out_ready,
      output in_ready, out_valid, pixel_out, out_last
   );

endinterface

// File: rtl/smoothing_line_buf.sv
// Two chained row buffers: tap1 is the pixel one row above, tap2 two rows above.
// Reads are combinational so a write on accept sees the old contents (read-before-write).
module smoothing_line_buf #(
   parameter  int unsigned DEPTH = 64,
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] tap1,
   output logic [WIDTH-1:0] tap2
);

   logic [WIDTH-1:0] row1_mem [DEPTH];
   logic [WIDTH-1:0] row2_mem [DEPTH];

   assign tap1 = row1_mem[addr];
   assign tap2 = row2_mem[addr];

   // Shift the column down one row on every accepted pixel; contents need no reset.
   always_ff @(posedge clk) begin
      if (we) begin
         row2_mem[addr] <= row1_mem[addr];
         row1_mem[addr] <= din;
      end
   end

endmodule

// File: rtl/smoothing_stream.sv
// Streaming 3x3 smoothing filter with valid/ready on both sides.
// Define SMOOTHING_GAUSS_EN for the 1-2-1 Gaussian kernel; default is a rounded box average.
module smoothing_stream
   import smoothing_pkg::*;
#(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned IMG_W = 64,
   parameter int unsigned IMG_H = 64
) (
   input logic              clk,
   input logic              rst,
   smoothing_stream_if.slave bus
);

   localparam int unsigned COL_W = $clog2(IMG_W);
   localparam int unsigned ROW_W = $clog2(IMG_H);
   localparam int unsigned SUM_W = sum_width(PIX_W);

`ifdef SMOOTHING_GAUSS_EN
   localparam int unsigned KERNEL_K [3][3] = GAUSS_K;
`else
   localparam int unsigned KERNEL_K [3][3] = BOX_K;
   localparam int unsigned SHIFT  = recip9_shift(PIX_W);
   localparam int unsigned PROD_W = SUM_W + SHIFT;
   localparam logic [SHIFT-1:0] MULT = SHIFT'(recip9_mult(PIX_W));
`endif

   logic [COL_W-1:0] col_q;
   logic [ROW_W-1:0] row_q;
   logic             accept;
   logic             emit;
   logic             emit_last;
   logic [PIX_W-1:0] tap1;
   logic [PIX_W-1:0] tap2;
   logic [PIX_W-1:0] new_col [3];
   logic [PIX_W-1:0] col_a_q [3];
   logic [PIX_W-1:0] col_b_q [3];
   logic [SUM_W-1:0] wsum;
   logic [SUM_W-1:0] rounded;
   logic [PIX_W-1:0] result;
   logic             out_valid_q;
   logic [PIX_W-1:0] pixel_out_q;
   logic             out_last_q;

   assign bus.in_ready  = !out_valid_q || bus.out_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.pixel_out = pixel_out_q;
   assign bus.out_last  = out_last_q;

   // Reset takes priority, so a pixel offered during reset is dropped.
   assign accept    = bus.in_valid && bus.in_ready && !rst;
   assign emit      = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
   assign emit_last = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));

   smoothing_line_buf #(
      .DEPTH (IMG_W),
      .WIDTH (PIX_W)
   ) u_line_buf (
      .clk  (clk),
      .we   (accept),
      .addr (col_q),
      .din  (bus.pixel_in),
      .tap1 (tap1),
      .tap2 (tap2)
   );

   // Window rows top to bottom: two rows up, one row up, current row.
   assign new_col[0] = tap2;
   assign new_col[1] = tap1;
   assign new_col[2] = bus.pixel_in;

   // Raster position of the next pixel to be accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else if (accept) begin
         if (col_q == COL_W'(IMG_W - 1)) begin
            col_q <= '0;
            row_q <= (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + 1'b1;
         end else begin
            col_q <= col_q + 1'b1;
         end
      end
   end

   // Two stored window columns; the third is the column arriving with the accepted pixel.
   always_ff @(posedge clk) begin
      if (accept) begin
         col_a_q <= col_b_q;
         col_b_q <= new_col;
      end
   end

   // Weighted window sum and rounding to the output pixel.
   always_comb begin
      wsum = '0;
      for (int r = 0; r < 3; r++) begin
         wsum = wsum + SUM_W'(KERNEL_K[r][0]) * SUM_W'(col_a_q[r])
                     + SUM_W'(KERNEL_K[r][1]) * SUM_W'(col_b_q[r])
                     + SUM_W'(KERNEL_K[r][2]) * SUM_W'(new_col[r]);
      end
`ifdef SMOOTHING_GAUSS_EN
      rounded = wsum + SUM_W'(ROUND_GAUSS);
      result  = PIX_W'(rounded >> GAUSS_SHIFT);
`else
      rounded = wsum + SUM_W'(ROUND_BOX);
      result  = PIX_W'((PROD_W'(rounded) * PROD_W'(MULT)) >> SHIFT);
`endif
   end

   // Single output register stage; holds while stalled, cleared once consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         pixel_out_q <= '0;
         out_last_q  <= 1'b0;
      end else if (emit) begin
         out_valid_q <= 1'b1;
         pixel_out_q <= result;
         out_last_q  <= emit_last;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_smoothing_stream.sv
// Self-checking bench for smoothing_stream on 4x4 frames (8-bit and 10-bit instances).
// Expected pixels come from a direct window model and are queued as the emitting pixel is sent.
module tb_smoothing_stream;

   localparam int unsigned IMG_W = 4;
   localparam int unsigned IMG_H = 4;

   typedef struct {
      int pix;
      bit last;
   } exp_t;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic bp_en = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_out8  = 0;
   int   n_out10 = 0;
   int   frm [IMG_H][IMG_W];
   exp_t q8 [$];
   int   q10 [$];
   exp_t e8;
   bit   stall_prev = 1'b0;
   int   held_pix;
   bit   held_last;

   always #5 clk = ~clk;

   smoothing_stream_if #(.PIX_W(8))  bus8 ();
   smoothing_stream_if #(.PIX_W(10)) bus10 ();

   smoothing_stream #(.PIX_W(8), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   smoothing_stream #(.PIX_W(10), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut10 (
      .clk (clk),
      .rst (rst),
      .bus (bus10)
   );

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int model(input int cr, input int cc);
      int acc = 0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
`ifdef SMOOTHING_GAUSS_EN
            acc += (2 - (dr < 0 ? -dr : dr)) * (2 - (dc < 0 ? -dc : dc)) * frm[cr+dr][cc+dc];
`else
            acc += frm[cr+dr][cc+dc];
`endif
         end
      end
`ifdef SMOOTHING_GAUSS_EN
      return (acc + 8) / 16;
`else
      return (acc + 4) / 9;
`endif
   endfunction

   // Random backpressure when enabled, otherwise always ready.
   always @(posedge clk) begin
      #1;
      bus8.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // 8-bit output monitor: scoreboard pop, hold-while-stalled and in_ready checks.
   always @(negedge clk) begin
      if (rst || !bus8.out_valid) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check_eq("hold_pix", longint'(bus8.pixel_out), longint'(held_pix));
            check_eq("hold_last", longint'(bus8.out_last), longint'(held_last));
         end
         if (bus8.out_ready) begin
            check_eq("out_expected", longint'(q8.size() > 0), 1);
            if (q8.size() > 0) begin
               e8 = q8.pop_front();
               check_eq("pix", longint'(bus8.pixel_out), longint'(e8.pix));
               check_eq("last", longint'(bus8.out_last), longint'(e8.last));
            end
            n_out8++;
            stall_prev = 1'b0;
         end else begin
            check_eq("in_ready_stall", longint'(bus8.in_ready), 0);
            stall_prev = 1'b1;
            held_pix   = int'(bus8.pixel_out);
            held_last  = bus8.out_last;
         end
      end
   end

   // 10-bit output monitor (always ready).
   always @(negedge clk) begin
      if (!rst && bus10.out_valid) begin
         check_eq("out10_expected", longint'(q10.size() > 0), 1);
         if (q10.size() > 0) begin
            check_eq("pix10", longint'(bus10.pixel_out), longint'(q10.pop_front()));
         end
         n_out10++;
      end
   end

   task automatic send8(input int r, input int c);
      int guard = 0;
      bus8.in_valid = 1'b1;
      bus8.pixel_in = 8'(frm[r][c]);
      forever begin
         @(negedge clk);
         if (bus8.in_ready) break;
         @(posedge clk);
         #1;
         guard++;
         if (guard > 200) begin
            $display("FAIL in_ready_timeout: got 0 after %0d cycles, expected 1", guard);
            $fatal(1, "in_ready stuck low");
         end
      end
      if (r >= 2 && c >= 2) begin
         q8.push_back('{pix: model(r - 1, c - 1),
                        last: (r == IMG_H - 1) && (c == IMG_W - 1)});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame8();
      for (int r = 0; r < IMG_H; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            send8(r, c);
         end
      end
      bus8.in_valid = 1'b0;
   endtask

   task automatic drain8(input string tag, input int base, input int n_exp);
      int guard = 0;
      while (q8.size() != 0 && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      repeat (3) @(posedge clk);
      #1;
      check_eq({tag, "_left"}, longint'(q8.size()), 0);
      check_eq({tag, "_count"}, longint'(n_out8 - base), longint'(n_exp));
   endtask

   task automatic fill_const(input int v);
      for (int r = 0; r < IMG_H; r++)
         for (int c = 0; c < IMG_W; c++) frm[r][c] = v;
   endtask

   task automatic fill_ramp();
      for (int r = 0; r < IMG_H; r++)
         for (int c = 0; c < IMG_W; c++) frm[r][c] = 4 * r + c;
   endtask

   initial begin
      int base;
      bus8.in_valid   = 1'b0;
      bus8.pixel_in   = '0;
      bus10.in_valid  = 1'b0;
      bus10.pixel_in  = '0;
      bus10.out_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_out_valid", longint'(bus8.out_valid), 0);
      check_eq("rst_pixel_out", longint'(bus8.pixel_out), 0);
      check_eq("rst_out_last", longint'(bus8.out_last), 0);
      check_eq("rst_in_ready", longint'(bus8.in_ready), 1);
      @(posedge clk);
      #1;

      // Constant frame.
      base = n_out8;
      fill_const(100);
      send_frame8();
      drain8("const", base, 4);

      // Ramp.
      base = n_out8;
      fill_ramp();
      send_frame8();
      drain8("ramp", base, 4);

      // Impulse at (1,1).
      base = n_out8;
      fill_const(0);
      frm[1][1] = 255;
      send_frame8();
      drain8("impulse", base, 4);

      // Full-scale 8-bit.
      base = n_out8;
      fill_const(255);
      send_frame8();
      drain8("max8", base, 4);

      // Full-scale 10-bit on the second instance.
      base = n_out10;
      for (int r = 0; r < IMG_H; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            bus10.in_valid = 1'b1;
            bus10.pixel_in = 10'd1023;
            @(negedge clk);
            check_eq("in_ready10", longint'(bus10.in_ready), 1);
            if (r >= 2 && c >= 2) q10.push_back(1023);
            @(posedge clk);
            #1;
         end
      end
      bus10.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("max10_count", longint'(n_out10 - base), 4);
      check_eq("max10_left", longint'(q10.size()), 0);

      // Ramp under random backpressure.
      base  = n_out8;
      bp_en = 1'b1;
      fill_ramp();
      send_frame8();
      drain8("bp", base, 4);
      bp_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset after 7 pixels; the pixel held during reset must be dropped.
      base = n_out8;
      fill_ramp();
      for (int i = 0; i < 7; i++) send8(i / IMG_W, i % IMG_W);
      bus8.pixel_in = 8'd200;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("rst_mid_valid", longint'(bus8.out_valid), 0);
      send_frame8();
      drain8("rst_mid", base, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
